// File: rtl/x_corr_pkg.sv
// x_corr_pkg -- shared definitions for the x_corr_search correlator.
//   * State encoding of the search state machine.
//   * clog2 helper with a minimum result of 1 bit.
//   * Width helpers for the complex product and the magnitude.
package x_corr_pkg;

  localparam logic [2:0] ST_LOAD_REF = 3'd0;
  localparam logic [2:0] ST_FILL     = 3'd1;
  localparam logic [2:0] ST_MAC      = 3'd2;
  localparam logic [2:0] ST_DRAIN    = 3'd3;
  localparam logic [2:0] ST_CMP      = 3'd4;
  localparam logic [2:0] ST_SHIFT    = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  // Ceiling log2, never less than 1 so it can size a vector directly.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(n)) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Width of one real or imaginary part of x*conj(y): a sum of two products.
  function automatic int prod_bits(input int xb, input int yb);
    return xb + yb + 1;
  endfunction

  // Width of re^2 + im^2 for an accumulator of width ab.
  function automatic int mag_width(input int ab);
    return 2 * ab + 1;
  endfunction

endpackage

// File: rtl/x_corr_search_cmac.sv
// x_corr_cmac -- conjugate complex multiply-accumulate.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   xi_i, xq_i           : signed x operand (real / imaginary)
//   yi_i, yq_i           : signed y operand, conjugated internally
//   clear_i              : load zero into the accumulator
//   acc_en_i             : add the registered product into the accumulator
//   acc_i_o, acc_q_o     : signed accumulator (real / imaginary)
//   mag_o                : acc_i^2 + acc_q^2, unsigned
// The product is registered, so the accumulator always lags the operands by
// one cycle; the caller adds one drain cycle after the last issue.
module x_corr_cmac
  import x_corr_pkg::*;
#(
  parameter int X_BITS   = 12,
  parameter int Y_BITS   = 12,
  parameter int ACC_BITS = 28,
  parameter int MAG_BITS = 57
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [X_BITS-1:0]   xi_i,
  input  logic signed [X_BITS-1:0]   xq_i,
  input  logic signed [Y_BITS-1:0]   yi_i,
  input  logic signed [Y_BITS-1:0]   yq_i,
  input  logic                       clear_i,
  input  logic                       acc_en_i,
  output logic signed [ACC_BITS-1:0] acc_i_o,
  output logic signed [ACC_BITS-1:0] acc_q_o,
  output logic        [MAG_BITS-1:0] mag_o
);

  localparam int PB = prod_bits(X_BITS, Y_BITS);

  logic signed [PB-1:0]       xi_e, xq_e, yi_e, yq_e;
  logic signed [PB-1:0]       re_d, im_d, re_q, im_q;
  logic signed [ACC_BITS-1:0] acc_i_q, acc_q_q;
  logic signed [MAG_BITS-1:0] ai_e, aq_e, sq_i, sq_q;

  assign xi_e = {{(PB-X_BITS){xi_i[X_BITS-1]}}, xi_i};
  assign xq_e = {{(PB-X_BITS){xq_i[X_BITS-1]}}, xq_i};
  assign yi_e = {{(PB-Y_BITS){yi_i[Y_BITS-1]}}, yi_i};
  assign yq_e = {{(PB-Y_BITS){yq_i[Y_BITS-1]}}, yq_i};

  // x * conj(y): (xi + j xq)(yi - j yq)
  assign re_d = xi_e * yi_e + xq_e * yq_e;
  assign im_d = xq_e * yi_e - xi_e * yq_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_q    <= '0;
      im_q    <= '0;
      acc_i_q <= '0;
      acc_q_q <= '0;
    end else begin
      re_q <= re_d;
      im_q <= im_d;
      if (clear_i) begin
        acc_i_q <= '0;
        acc_q_q <= '0;
      end else if (acc_en_i) begin
        acc_i_q <= acc_i_q + {{(ACC_BITS-PB){re_q[PB-1]}}, re_q};
        acc_q_q <= acc_q_q + {{(ACC_BITS-PB){im_q[PB-1]}}, im_q};
      end
    end
  end

  // Squares are computed at full magnitude width; the true values fit, so
  // truncation of the signed product to MAG_BITS loses nothing.
  assign ai_e = {{(MAG_BITS-ACC_BITS){acc_i_q[ACC_BITS-1]}}, acc_i_q};
  assign aq_e = {{(MAG_BITS-ACC_BITS){acc_q_q[ACC_BITS-1]}}, acc_q_q};
  assign sq_i = ai_e * ai_e;
  assign sq_q = aq_e * aq_e;

  assign acc_i_o = acc_i_q;
  assign acc_q_o = acc_q_q;
  assign mag_o   = $unsigned(sq_i + sq_q);

endmodule

// File: rtl/x_corr_search.sv
// x_corr_search -- lag search by streaming complex cross-correlation.
// Stores a complex reference y of `length` samples, then for each of
// `num_lags` lags computes sum_n x[k+n]*conj(y[n]) and reports the argmax.
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   yi, yq / m_axis_y_tvalid / s_axis_y_tready : reference sample stream
//   xi, xq / m_axis_x_tvalid / s_axis_x_tready : input sample stream
//   threshold                          : detection threshold on magnitude
//   new_ref                            : at result handshake, 1 = reload y
//   s_axis_tvalid / m_axis_tready      : result handshake
//   index, peak_i, peak_q              : peak lag and its complex sum
//   out_max                            : top bits of peak magnitude
//   detect                             : peak magnitude >= threshold
module x_corr_search
  import x_corr_pkg::*;
#(
  parameter int x_bits              = 12,
  parameter int y_bits              = 12,
  parameter int length              = 8,
  parameter int length_counter_bits = 3,
  parameter int num_lags            = 8,
  parameter int lag_bits            = 3,
  parameter int acc_bits            = 28,
  parameter int mag_bits            = 57,
  parameter int out_max_bits        = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic signed [y_bits-1:0]       yi,
  input  logic signed [y_bits-1:0]       yq,
  input  logic                           m_axis_y_tvalid,
  output logic                           s_axis_y_tready,
  input  logic signed [x_bits-1:0]       xi,
  input  logic signed [x_bits-1:0]       xq,
  input  logic                           m_axis_x_tvalid,
  output logic                           s_axis_x_tready,
  input  logic        [mag_bits-1:0]     threshold,
  input  logic                           new_ref,
  output logic                           s_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic        [lag_bits-1:0]     index,
  output logic signed [acc_bits-1:0]     peak_i,
  output logic signed [acc_bits-1:0]     peak_q,
  output logic        [out_max_bits-1:0] out_max,
  output logic                           detect
);

  localparam int SB = clog2_min1(2 * length);
  localparam logic [length_counter_bits-1:0] CNT_LAST = length_counter_bits'(length - 1);
  localparam logic [lag_bits-1:0]            LAG_LAST = lag_bits'(num_lags - 1);

  logic [2:0]                     state_q, state_d;
  logic [length_counter_bits-1:0] cnt_q, cnt_d;
  logic [length_counter_bits-1:0] head_q, head_d;
  logic [lag_bits-1:0]            lag_q, lag_d;

  logic signed [y_bits-1:0] y_re_mem [length];
  logic signed [y_bits-1:0] y_im_mem [length];
  logic signed [x_bits-1:0] x_re_mem [length];
  logic signed [x_bits-1:0] x_im_mem [length];

  logic [SB-1:0]                  rd_sum, rd_wrap;
  logic [length_counter_bits-1:0] rd_addr, x_wr_addr;
  logic                           y_we, x_we;

  logic signed [acc_bits-1:0] acc_i, acc_q;
  logic        [mag_bits-1:0] mag;
  logic                       clear, acc_en, take;

  logic        [mag_bits-1:0]     best_mag_q;
  logic        [lag_bits-1:0]     index_q;
  logic signed [acc_bits-1:0]     peak_i_q, peak_q_q;
  logic        [out_max_bits-1:0] out_max_q;
  logic                           detect_q;

  // Handshake readies depend on state only.
  assign s_axis_y_tready = (state_q == ST_LOAD_REF);
  assign s_axis_x_tready = (state_q == ST_FILL) || (state_q == ST_SHIFT);
  assign s_axis_tvalid   = (state_q == ST_DONE);

  assign y_we = (state_q == ST_LOAD_REF) && m_axis_y_tvalid;
  assign x_we = s_axis_x_tready && m_axis_x_tvalid;
  // SHIFT overwrites the oldest entry, which is the one at head.
  assign x_wr_addr = (state_q == ST_SHIFT) ? head_q : cnt_q;

  // Circular read: x[(head + n) mod length].
  assign rd_sum  = SB'(head_q) + SB'(cnt_q);
  assign rd_wrap = (rd_sum >= SB'(length)) ? (rd_sum - SB'(length)) : rd_sum;
  assign rd_addr = length_counter_bits'(rd_wrap);

  always_ff @(posedge clk) begin
    if (y_we) begin
      y_re_mem[cnt_q] <= yi;
      y_im_mem[cnt_q] <= yq;
    end
    if (x_we) begin
      x_re_mem[x_wr_addr] <= xi;
      x_im_mem[x_wr_addr] <= xq;
    end
  end

  assign clear  = (state_q == ST_MAC) && (cnt_q == '0);
  assign acc_en = ((state_q == ST_MAC) && (cnt_q != '0)) || (state_q == ST_DRAIN);

  x_corr_cmac #(
    .X_BITS  (x_bits),
    .Y_BITS  (y_bits),
    .ACC_BITS(acc_bits),
    .MAG_BITS(mag_bits)
  ) u_cmac (
    .clk     (clk),
    .rst_n   (rst_n),
    .xi_i    (x_re_mem[rd_addr]),
    .xq_i    (x_im_mem[rd_addr]),
    .yi_i    (y_re_mem[cnt_q]),
    .yq_i    (y_im_mem[cnt_q]),
    .clear_i (clear),
    .acc_en_i(acc_en),
    .acc_i_o (acc_i),
    .acc_q_o (acc_q),
    .mag_o   (mag)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    head_d  = head_q;
    lag_d   = lag_q;
    case (state_q)
      ST_LOAD_REF: begin
        if (m_axis_y_tvalid) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_FILL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (m_axis_x_tvalid) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            head_d  = '0;
            lag_d   = '0;
            state_d = ST_MAC;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_MAC: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: state_d = ST_CMP;
      ST_CMP:   state_d = (lag_q == LAG_LAST) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: begin
        if (m_axis_x_tvalid) begin
          head_d  = (head_q == CNT_LAST) ? '0 : head_q + 1'b1;
          lag_d   = lag_q + 1'b1;
          state_d = ST_MAC;
        end
      end
      ST_DONE: begin
        if (m_axis_tready) begin
          cnt_d   = '0;
          state_d = new_ref ? ST_LOAD_REF : ST_FILL;
        end
      end
      default: state_d = ST_LOAD_REF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD_REF;
      cnt_q   <= '0;
      head_q  <= '0;
      lag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      lag_q   <= lag_d;
    end
  end

  // Lag 0 always loads: it is equivalent to comparing against a cleared
  // max of zero (a zero magnitude means a zero peak at index 0) and keeps a
  // stale previous frame from surviving into an all-zero frame. Later lags
  // need a strictly larger magnitude, so ties keep the earlier lag.
  assign take = (state_q == ST_CMP) && ((lag_q == '0) || (mag > best_mag_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_mag_q <= '0;
      index_q    <= '0;
      peak_i_q   <= '0;
      peak_q_q   <= '0;
      out_max_q  <= '0;
      detect_q   <= 1'b0;
    end else if (state_q == ST_FILL) begin
      best_mag_q <= '0;
    end else if (take) begin
      best_mag_q <= mag;
      index_q    <= lag_q;
      peak_i_q   <= acc_i;
      peak_q_q   <= acc_q;
      out_max_q  <= mag[mag_bits-1 -: out_max_bits];
      detect_q   <= (mag >= threshold);
    end
  end

  assign index   = index_q;
  assign peak_i  = peak_i_q;
  assign peak_q  = peak_q_q;
  assign out_max = out_max_q;
  assign detect  = detect_q;

endmodule

// File: tb/tb_x_corr_search.sv
// tb_x_corr_search -- scoreboard bench for x_corr_search (length=4, num_lags=4).
// Expected results are computed from the stimulus arrays and queued when a
// frame is sent; a negedge monitor pops and compares on each result handshake.
module tb_x_corr_search;

  localparam int L   = 4;
  localparam int N   = 4;
  localparam int XB  = 12;
  localparam int YB  = 12;
  localparam int LCB = 2;
  localparam int LB  = 2;
  localparam int AB  = 28;
  localparam int MB  = 57;
  localparam int OB  = 57;
  localparam int LATENCY = N * (L + 2) + (N - 1);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic signed [YB-1:0] yi = '0, yq = '0;
  logic                 m_axis_y_tvalid = 1'b0;
  logic                 s_axis_y_tready;
  logic signed [XB-1:0] xi = '0, xq = '0;
  logic                 m_axis_x_tvalid = 1'b0;
  logic                 s_axis_x_tready;
  logic        [MB-1:0] threshold = '0;
  logic                 new_ref = 1'b0;
  logic                 s_axis_tvalid;
  logic                 m_axis_tready = 1'b0;
  logic        [LB-1:0] index;
  logic signed [AB-1:0] peak_i, peak_q;
  logic        [OB-1:0] out_max;
  logic                 detect;

  x_corr_search #(
    .x_bits(XB), .y_bits(YB), .length(L), .length_counter_bits(LCB),
    .num_lags(N), .lag_bits(LB), .acc_bits(AB), .mag_bits(MB), .out_max_bits(OB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .yi(yi), .yq(yq), .m_axis_y_tvalid(m_axis_y_tvalid), .s_axis_y_tready(s_axis_y_tready),
    .xi(xi), .xq(xq), .m_axis_x_tvalid(m_axis_x_tvalid), .s_axis_x_tready(s_axis_x_tready),
    .threshold(threshold), .new_ref(new_ref),
    .s_axis_tvalid(s_axis_tvalid), .m_axis_tready(m_axis_tready),
    .index(index), .peak_i(peak_i), .peak_q(peak_q), .out_max(out_max), .detect(detect)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int     idx;
    longint pi;
    longint pq;
    longint mag;
    bit     det;
  } exp_t;
  exp_t sb_q[$];

  int ref_i[L], ref_q[L];
  int xs_i[L+N-1], xs_q[L+N-1];
  int last_acc_cyc = 0, fill_cyc = 0, done_cyc = 0;
  bit stall_en = 1'b0;

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (s_axis_tvalid && m_axis_tready) begin
      $display("result idx=%0d peak=(%0d,%0d) mag=%0d det=%0b", index,
               $signed(peak_i), $signed(peak_q), out_max, detect);
      if (sb_q.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL sb_underflow: unexpected result handshake, none required");
      end else begin
        e = sb_q.pop_front();
        compared++;
        if (int'(index) !== e.idx) begin
          mismatched++; $display("FAIL index: got %0d required %0d", index, e.idx);
        end
        compared++;
        if (longint'($signed(peak_i)) !== e.pi) begin
          mismatched++; $display("FAIL peak_i: got %0d required %0d", $signed(peak_i), e.pi);
        end
        compared++;
        if (longint'($signed(peak_q)) !== e.pq) begin
          mismatched++; $display("FAIL peak_q: got %0d required %0d", $signed(peak_q), e.pq);
        end
        compared++;
        if (longint'(out_max) !== e.mag) begin
          mismatched++; $display("FAIL out_max: got %0d required %0d", out_max, e.mag);
        end
        compared++;
        if (detect !== e.det) begin
          mismatched++; $display("FAIL detect: got %0b required %0b", detect, e.det);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- drivers and model ----------------
  task automatic push_y(input int vi, input int vq);
    int guard;
    guard = 0;
    if (stall_en && $urandom_range(0, 2) == 0) begin
      m_axis_y_tvalid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    yi = YB'(vi); yq = YB'(vq); m_axis_y_tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis_y_tready && guard < 500) begin @(negedge clk); guard++; end
    if (!s_axis_y_tready) begin
      compared++; mismatched++;
      $display("FAIL y_accept_timeout: tready=%0b required 1", s_axis_y_tready);
    end
    @(posedge clk); #1;
  endtask

  task automatic push_x(input int vi, input int vq);
    int guard;
    guard = 0;
    if (stall_en && $urandom_range(0, 2) == 0) begin
      m_axis_x_tvalid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    xi = XB'(vi); xq = XB'(vq); m_axis_x_tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis_x_tready && guard < 500) begin @(negedge clk); guard++; end
    if (!s_axis_x_tready) begin
      compared++; mismatched++;
      $display("FAIL x_accept_timeout: tready=%0b required 1", s_axis_x_tready);
    end
    @(posedge clk); #1;
    last_acc_cyc = cyc;
  endtask

  task automatic load_ref();
    for (int n = 0; n < L; n++) push_y(ref_i[n], ref_q[n]);
    m_axis_y_tvalid = 1'b0;
  endtask

  // Reference model: running max starts at 0, replaced only by a strictly
  // larger magnitude, detect compares the final peak against threshold.
  task automatic model_push(input longint thr);
    exp_t   e;
    longint si, sq, m, best;
    best = 0; e.idx = 0; e.pi = 0; e.pq = 0;
    for (int k = 0; k < N; k++) begin
      si = 0; sq = 0;
      for (int n = 0; n < L; n++) begin
        si += longint'(xs_i[k+n]) * ref_i[n] + longint'(xs_q[k+n]) * ref_q[n];
        sq += longint'(xs_q[k+n]) * ref_i[n] - longint'(xs_i[k+n]) * ref_q[n];
      end
      m = si * si + sq * sq;
      if (m > best) begin
        best = m; e.idx = k; e.pi = si; e.pq = sq;
      end
    end
    e.mag = best;
    e.det = (best >= thr);
    sb_q.push_back(e);
  endtask

  task automatic send_frame(input longint thr);
    threshold = MB'(thr);
    model_push(thr);
    for (int i = 0; i < L + N - 1; i++) begin
      push_x(xs_i[i], xs_q[i]);
      if (i == L - 1) fill_cyc = last_acc_cyc;
    end
    m_axis_x_tvalid = 1'b0;
  endtask

  task automatic finish_frame(input bit nr);
    int guard;
    guard = 0;
    while (!s_axis_tvalid && guard < 1000) begin @(posedge clk); #1; guard++; end
    if (!s_axis_tvalid) begin
      compared++; mismatched++;
      $display("FAIL result_timeout: tvalid=%0b required 1", s_axis_tvalid);
    end else begin
      done_cyc = cyc;
      new_ref = nr; m_axis_tready = 1'b1;
      @(posedge clk); #1;
      m_axis_tready = 1'b0; new_ref = 1'b0;
    end
  endtask

  task automatic set_real_peak();
    ref_i = '{1, 2, 0, 0}; ref_q = '{0, 0, 0, 0};
    xs_i = '{0, 0, 3, 1, 0, 0, 0}; xs_q = '{0, 0, 0, 0, 0, 0, 0};
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    compared++; if (s_axis_y_tready !== 1'b1) begin mismatched++; $display("FAIL rst_y_tready: got %0b required 1", s_axis_y_tready); end
    compared++; if (s_axis_x_tready !== 1'b0) begin mismatched++; $display("FAIL rst_x_tready: got %0b required 0", s_axis_x_tready); end
    compared++; if (s_axis_tvalid !== 1'b0) begin mismatched++; $display("FAIL rst_tvalid: got %0b required 0", s_axis_tvalid); end
    compared++; if (index !== '0) begin mismatched++; $display("FAIL rst_index: got %0d required 0", index); end
    compared++; if (peak_i !== '0) begin mismatched++; $display("FAIL rst_peak_i: got %0d required 0", peak_i); end
    compared++; if (peak_q !== '0) begin mismatched++; $display("FAIL rst_peak_q: got %0d required 0", peak_q); end
    compared++; if (out_max !== '0) begin mismatched++; $display("FAIL rst_out_max: got %0d required 0", out_max); end
    compared++; if (detect !== 1'b0) begin mismatched++; $display("FAIL rst_detect: got %0b required 0", detect); end
    @(posedge clk); #1;
  endtask

  task automatic test_real_peak();
    set_real_peak();
    load_ref();
    send_frame(0);
    finish_frame(1'b1);
    compared++;
    if (done_cyc - fill_cyc !== LATENCY) begin
      mismatched++;
      $display("FAIL latency: got %0d cycles required %0d", done_cyc - fill_cyc, LATENCY);
    end
  endtask

  task automatic test_conjugate();
    ref_i = '{0, 0, 0, 0}; ref_q = '{1, 0, 0, 0};
    xs_i = '{0, 0, 0, 2, 0, 0, 0}; xs_q = '{0, 0, 0, 0, 0, 0, 0};
    load_ref();
    send_frame(0);
    finish_frame(1'b1);
  endtask

  task automatic test_tie();
    ref_i = '{1, 0, 0, 0}; ref_q = '{0, 0, 0, 0};
    xs_i = '{1, 1, 1, 1, 1, 1, 1}; xs_q = '{0, 0, 0, 0, 0, 0, 0};
    load_ref();
    send_frame(0);
    finish_frame(1'b1);
  endtask

  task automatic test_threshold();
    set_real_peak();
    load_ref();
    send_frame(36);
    finish_frame(1'b0);
    send_frame(37);
    finish_frame(1'b0);
  endtask

  task automatic test_back_to_back();
    int guard;
    guard = 0;
    send_frame(0);
    while (!s_axis_tvalid && guard < 1000) begin @(posedge clk); #1; guard++; end
    compared++;
    if (!s_axis_tvalid) begin mismatched++; $display("FAIL bp_done_timeout: tvalid=%0b required 1", s_axis_tvalid); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      compared++; if (s_axis_tvalid !== 1'b1) begin mismatched++; $display("FAIL bp_tvalid: cycle %0d got %0b required 1", c, s_axis_tvalid); end
      compared++; if (s_axis_x_tready !== 1'b0) begin mismatched++; $display("FAIL bp_x_tready: cycle %0d got %0b required 0", c, s_axis_x_tready); end
      compared++; if (index !== LB'(1)) begin mismatched++; $display("FAIL bp_index: cycle %0d got %0d required 1", c, index); end
      compared++; if (peak_i !== AB'(6)) begin mismatched++; $display("FAIL bp_peak_i: cycle %0d got %0d required 6", c, peak_i); end
      compared++; if (out_max !== OB'(36)) begin mismatched++; $display("FAIL bp_out_max: cycle %0d got %0d required 36", c, out_max); end
    end
    @(posedge clk); #1;
    finish_frame(1'b0);
    @(negedge clk);
    compared++; if (s_axis_x_tready !== 1'b1) begin mismatched++; $display("FAIL reuse_fill: x_tready got %0b required 1", s_axis_x_tready); end
    compared++; if (s_axis_y_tready !== 1'b0) begin mismatched++; $display("FAIL reuse_no_load: y_tready got %0b required 0", s_axis_y_tready); end
    @(posedge clk); #1;
    send_frame(0);
    finish_frame(1'b1);
  endtask

  task automatic test_reset_mid_mac();
    set_real_peak();
    load_ref();
    for (int i = 0; i < L + 2; i++) push_x(xs_i[i], xs_q[i]);
    m_axis_x_tvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    compared++; if (index !== '0) begin mismatched++; $display("FAIL mid_rst_index: got %0d required 0", index); end
    compared++; if (peak_i !== '0) begin mismatched++; $display("FAIL mid_rst_peak_i: got %0d required 0", peak_i); end
    compared++; if (peak_q !== '0) begin mismatched++; $display("FAIL mid_rst_peak_q: got %0d required 0", peak_q); end
    compared++; if (out_max !== '0) begin mismatched++; $display("FAIL mid_rst_out_max: got %0d required 0", out_max); end
    compared++; if (detect !== 1'b0) begin mismatched++; $display("FAIL mid_rst_detect: got %0b required 0", detect); end
    compared++; if (s_axis_tvalid !== 1'b0) begin mismatched++; $display("FAIL mid_rst_tvalid: got %0b required 0", s_axis_tvalid); end
    compared++; if (s_axis_x_tready !== 1'b0) begin mismatched++; $display("FAIL mid_rst_x_tready: got %0b required 0", s_axis_x_tready); end
    compared++; if (s_axis_y_tready !== 1'b1) begin mismatched++; $display("FAIL mid_rst_y_tready: got %0b required 1", s_axis_y_tready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_real_peak();
    load_ref();
    send_frame(0);
    finish_frame(1'b1);
  endtask

  task automatic test_random();
    stall_en = 1'b1;
    for (int f = 0; f < 4; f++) begin
      for (int n = 0; n < L; n++) begin
        ref_i[n] = int'($urandom_range(0, 600)) - 300;
        ref_q[n] = int'($urandom_range(0, 600)) - 300;
      end
      for (int i = 0; i < L + N - 1; i++) begin
        xs_i[i] = int'($urandom_range(0, 4000)) - 2000;
        xs_q[i] = int'($urandom_range(0, 4000)) - 2000;
      end
      load_ref();
      send_frame((f % 2 == 0) ? longint'(1) : longint'(64'h1_0000_0000_0000));
      finish_frame(1'b1);
    end
    stall_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_real_peak();
    test_conjugate();
    test_tie();
    test_threshold();
    test_back_to_back();
    test_reset_mid_mac();
    test_random();
    compared++;
    if (sb_q.size() != 0) begin
      mismatched++;
      $display("FAIL sb_leftover: %0d results outstanding, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
